// File: rtl/snoop_bus_pkg.sv
// Shared snoop-bus definitions: bus command encodings, arbiter state encoding
// and core identifiers. The arbiter and the cache controllers use the same constants.
package snoop_bus_pkg;

    typedef logic [1:0] bus_cmd_t;

    localparam bus_cmd_t CMD_IDLE   = 2'b00;
    localparam bus_cmd_t CMD_BUSRD  = 2'b01;
    localparam bus_cmd_t CMD_BUSRDX = 2'b10;
    localparam bus_cmd_t CMD_FLUSH  = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN  = 2'b01,
        ARB_TURN = 2'b10
    } arb_state_e;

    localparam logic CORE_0 = 1'b0;
    localparam logic CORE_1 = 1'b1;

    function automatic logic otherCore(input logic core);
        return ~core;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the requester that
// did not win last time is chosen.
module rr_pick2
    import snoop_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = CORE_0;
        case (req)
            2'b01:   winner = CORE_0;
            2'b10:   winner = CORE_1;
            default: winner = otherCore(last);
        endcase
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop-bus owner for the two cache controllers: round-robin grant, one idle
// turnaround cycle between owners, and a hold-time watchdog. All outputs are registered.
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter int DATA_BITS = 16,
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic [1:0]           cmd_0,
    input  logic [ADDR_BITS-1:0] addr_0,
    input  logic [DATA_BITS-1:0] data_0,
    input  logic                 done_0,
    input  logic                 req_1,
    input  logic [1:0]           cmd_1,
    input  logic [ADDR_BITS-1:0] addr_1,
    input  logic [DATA_BITS-1:0] data_1,
    input  logic                 done_1,
    output logic                 gnt_0,
    output logic                 gnt_1,
    output logic [1:0]           bus_cmd,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_data,
    output logic                 busy,
    output logic                 timeout
);

    localparam int                  CNT_BITS  = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(MAX_HOLD - 1);

    arb_state_e           state_q, state_d;
    logic                 lastOwner_q, lastOwner_d;
    logic [CNT_BITS-1:0]  holdCnt_q, holdCnt_d;
    logic                 gnt0_q, gnt0_d;
    logic                 gnt1_q, gnt1_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    bus_cmd_t             busCmd_q, busCmd_d;
    logic [ADDR_BITS-1:0] busAddr_q, busAddr_d;
    logic [DATA_BITS-1:0] busData_q, busData_d;

    logic                 pickValid;
    logic                 pickWinner;
    logic                 ownerReq;
    logic                 ownerDone;
    bus_cmd_t             ownerCmd;
    logic [ADDR_BITS-1:0] ownerAddr;
    logic [DATA_BITS-1:0] ownerData;
    logic                 watchdogHit;
    logic                 releaseNow;
    logic                 forcedRelease;

    rr_pick2 u_pick (
        .req    ({req_1, req_0}),
        .last   (lastOwner_q),
        .valid  (pickValid),
        .winner (pickWinner)
    );

    // While a core owns the bus lastOwner_q names it, so the owner's signals
    // are selected from it; the other core's inputs never reach the logic.
    always_comb begin
        ownerReq  = (lastOwner_q == CORE_1) ? req_1  : req_0;
        ownerDone = (lastOwner_q == CORE_1) ? done_1 : done_0;
        ownerCmd  = (lastOwner_q == CORE_1) ? cmd_1  : cmd_0;
        ownerAddr = (lastOwner_q == CORE_1) ? addr_1 : addr_0;
        ownerData = (lastOwner_q == CORE_1) ? data_1 : data_0;
    end

    assign watchdogHit = (holdCnt_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            lastOwner_q <= CORE_1;
            holdCnt_q   <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busCmd_q    <= CMD_IDLE;
            busAddr_q   <= '0;
            busData_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            holdCnt_q   <= holdCnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            busCmd_q    <= busCmd_d;
            busAddr_q   <= busAddr_d;
            busData_q   <= busData_d;
        end
    end

    // TURN arbitrates exactly like IDLE, so a waiting core is granted right
    // after the single turnaround cycle.
    always_comb begin
        state_d       = state_q;
        lastOwner_d   = lastOwner_q;
        holdCnt_d     = holdCnt_q;
        releaseNow    = 1'b0;
        forcedRelease = 1'b0;
        case (state_q)
            ARB_IDLE, ARB_TURN: begin
                if (pickValid) begin
                    state_d     = ARB_OWN;
                    lastOwner_d = pickWinner;
                    holdCnt_d   = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN: begin
                if (ownerDone || !ownerReq || watchdogHit) begin
                    state_d       = ARB_TURN;
                    releaseNow    = 1'b1;
                    forcedRelease = watchdogHit && !ownerDone;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt0_d    = (state_d == ARB_OWN) && (lastOwner_d == CORE_0);
        gnt1_d    = (state_d == ARB_OWN) && (lastOwner_d == CORE_1);
        busy_d    = (state_d == ARB_OWN);
        timeout_d = forcedRelease;
        busCmd_d  = CMD_IDLE;
        busAddr_d = busAddr_q;
        busData_d = busData_q;
        if ((state_q == ARB_OWN) && !releaseNow) begin
            busCmd_d  = ownerCmd;
            busAddr_d = ownerAddr;
            busData_d = ownerData;
        end
    end

    assign gnt_0    = gnt0_q;
    assign gnt_1    = gnt1_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;
    assign bus_cmd  = busCmd_q;
    assign bus_addr = busAddr_q;
    assign bus_data = busData_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: stimulus pushes the expected ownership
// episodes into a queue, and a monitor pops and checks each one as its grant falls.
module tb_snoop_bus_arbiter;
    import snoop_bus_pkg::*;

    localparam int ADDR_BITS = 11;
    localparam int DATA_BITS = 16;
    localparam int MAX_HOLD  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req_0, req_1, done_0, done_1;
    logic [1:0]           cmd_0, cmd_1;
    logic [ADDR_BITS-1:0] addr_0, addr_1;
    logic [DATA_BITS-1:0] data_0, data_1;
    logic                 gnt_0, gnt_1, busy, timeout;
    logic [1:0]           bus_cmd;
    logic [ADDR_BITS-1:0] bus_addr;
    logic [DATA_BITS-1:0] bus_data;

    typedef struct {
        int                   core;
        int                   held;
        logic [1:0]           cmd;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
        logic                 tout;
    } txn_t;

    txn_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   grantCnt[2] = '{0, 0};

    snoop_bus_arbiter #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_0    (req_0),
        .cmd_0    (cmd_0),
        .addr_0   (addr_0),
        .data_0   (data_0),
        .done_0   (done_0),
        .req_1    (req_1),
        .cmd_1    (cmd_1),
        .addr_1   (addr_1),
        .data_1   (data_1),
        .done_1   (done_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .bus_cmd  (bus_cmd),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .busy     (busy),
        .timeout  (timeout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // One comparison: counted, and reported with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one core's request-side inputs together.
    task automatic applyStimulus(input int core, input logic req, input logic [1:0] cmd,
                                 input logic [ADDR_BITS-1:0] addr, input logic [DATA_BITS-1:0] data);
        if (core == 0) begin
            req_0 = req; cmd_0 = cmd; addr_0 = addr; data_0 = data;
        end else begin
            req_1 = req; cmd_1 = cmd; addr_1 = addr; data_1 = data;
        end
    endtask

    task automatic pushExpected(input int core, input int held, input logic [1:0] cmd,
                                input logic [ADDR_BITS-1:0] addr, input logic [DATA_BITS-1:0] data,
                                input logic tout);
        txn_t t;
        t.core = core; t.held = held; t.cmd = cmd; t.addr = addr; t.data = data; t.tout = tout;
        expQ.push_back(t);
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, checks the per-cycle invariants and
    // closes an ownership episode when its grant drops.
    initial begin : monitor
        logic                 prev0, prev1, inTxn;
        int                   held, curCore;
        logic [1:0]           seenCmd;
        logic [ADDR_BITS-1:0] seenAddr;
        logic [DATA_BITS-1:0] seenData;
        txn_t                 e;
        prev0 = 1'b0; prev1 = 1'b0; inTxn = 1'b0; held = 0; curCore = 0;
        seenCmd = '0; seenAddr = '0; seenData = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                inTxn = 1'b0; prev0 = 1'b0; prev1 = 1'b0;
                continue;
            end
            checkOutput("gnt_mutex", 32'(gnt_0 & gnt_1), 32'd0);
            checkOutput("busy_eq_gnt", 32'(busy), 32'(gnt_0 | gnt_1));
            checkOutput("turn_gap", 32'((prev0 && gnt_1) || (prev1 && gnt_0)), 32'd0);
            if (gnt_0 || gnt_1) begin
                if (!inTxn) begin
                    inTxn   = 1'b1;
                    held    = 0;
                    curCore = gnt_1 ? 1 : 0;
                end
                held++;
                if (held == 2) begin
                    seenCmd = bus_cmd; seenAddr = bus_addr; seenData = bus_data;
                end
                checkOutput("timeout_quiet", 32'(timeout), 32'd0);
            end else begin
                checkOutput("idle_bus_cmd", 32'(bus_cmd), 32'(CMD_IDLE));
                if (inTxn) begin
                    inTxn = 1'b0;
                    checkOutput("exp_queue_nonempty", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("owner_core", 32'(curCore), 32'(e.core));
                        checkOutput("held_cycles", 32'(held), 32'(e.held));
                        checkOutput("bus_cmd_lag", 32'(seenCmd), 32'(e.cmd));
                        checkOutput("bus_addr_lag", 32'(seenAddr), 32'(e.addr));
                        checkOutput("bus_data_lag", 32'(seenData), 32'(e.data));
                        checkOutput("turn_addr_hold", 32'(bus_addr), 32'(e.addr));
                        checkOutput("release_timeout", 32'(timeout), 32'(e.tout));
                        grantCnt[curCore]++;
                    end
                end else begin
                    checkOutput("timeout_quiet", 32'(timeout), 32'd0);
                end
            end
            prev0 = gnt_0;
            prev1 = gnt_1;
        end
    end

    initial begin : stimulus
        int base0, base1;
        req_0 = 0; req_1 = 0; done_0 = 0; done_1 = 0;
        cmd_0 = '0; cmd_1 = '0; addr_0 = '0; addr_1 = '0; data_0 = '0; data_1 = '0;
        #1 rst = 1'b0;
        #10;
        checkOutput("rst_gnt_0", 32'(gnt_0), 32'd0);
        checkOutput("rst_gnt_1", 32'(gnt_1), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_bus_cmd", 32'(bus_cmd), 32'd0);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_bus_data", 32'(bus_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(2);

        $display("[TB] simultaneous first request");
        pushExpected(0, 2, CMD_BUSRD, 11'h0A0, 16'h1111, 1'b0);
        pushExpected(1, 2, CMD_BUSRDX, 11'h0B0, 16'h2222, 1'b0);
        applyStimulus(0, 1'b1, CMD_BUSRD, 11'h0A0, 16'h1111);
        applyStimulus(1, 1'b1, CMD_BUSRDX, 11'h0B0, 16'h2222);
        tick(2);
        done_0 = 1; req_0 = 0;
        tick(1);
        done_0 = 0;
        tick(2);
        done_1 = 1; req_1 = 0;
        tick(1);
        done_1 = 0;
        tick(2);

        $display("[TB] fairness under continuous requests");
        base0 = grantCnt[0];
        base1 = grantCnt[1];
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) pushExpected(0, 2, CMD_BUSRDX, 11'h2C0, 16'hA5A5, 1'b0);
            else            pushExpected(1, 2, CMD_FLUSH, 11'h3C0, 16'h5A5A, 1'b0);
        end
        applyStimulus(0, 1'b1, CMD_BUSRDX, 11'h2C0, 16'hA5A5);
        applyStimulus(1, 1'b1, CMD_FLUSH, 11'h3C0, 16'h5A5A);
        for (int i = 0; i < 8; i++) begin
            tick(2);
            if (i == 7) begin
                req_0 = 0; req_1 = 0;
            end
            if (i % 2 == 0) done_0 = 1;
            else            done_1 = 1;
            tick(1);
            done_0 = 0; done_1 = 0;
        end
        tick(2);
        checkOutput("fair_count_core0", 32'(grantCnt[0] - base0), 32'd4);
        checkOutput("fair_count_core1", 32'(grantCnt[1] - base1), 32'd4);

        $display("[TB] single requester");
        pushExpected(0, 3, CMD_BUSRD, 11'h1A4, 16'hBEEF, 1'b0);
        applyStimulus(0, 1'b1, CMD_BUSRD, 11'h1A4, 16'hBEEF);
        tick(3);
        done_0 = 1; req_0 = 0;
        tick(1);
        done_0 = 0;
        tick(2);

        $display("[TB] watchdog forced release");
        pushExpected(1, MAX_HOLD, CMD_BUSRD, 11'h155, 16'h0F0F, 1'b1);
        applyStimulus(1, 1'b1, CMD_BUSRD, 11'h155, 16'h0F0F);
        tick(MAX_HOLD + 1);
        req_1 = 0;
        tick(2);

        $display("[TB] done on the watchdog cycle");
        pushExpected(1, MAX_HOLD, CMD_BUSRDX, 11'h2AA, 16'hF0F0, 1'b0);
        applyStimulus(1, 1'b1, CMD_BUSRDX, 11'h2AA, 16'hF0F0);
        tick(MAX_HOLD);
        done_1 = 1; req_1 = 0;
        tick(1);
        done_1 = 0;
        tick(2);

        $display("[TB] abandon with non-owner noise");
        pushExpected(0, 3, CMD_BUSRDX, 11'h0F0, 16'h1234, 1'b0);
        applyStimulus(0, 1'b1, CMD_BUSRDX, 11'h0F0, 16'h1234);
        tick(1);
        applyStimulus(1, 1'b0, CMD_FLUSH, 11'h7FF, 16'hFFFF);
        done_1 = 1;
        tick(1);
        done_1 = 0;
        tick(1);
        req_0 = 0;
        tick(3);

        $display("[TB] asynchronous reset while owned");
        applyStimulus(0, 1'b1, CMD_FLUSH, 11'h321, 16'h4321);
        tick(2);
        checkOutput("pre_reset_gnt_0", 32'(gnt_0), 32'd1);
        checkOutput("pre_reset_bus_cmd", 32'(bus_cmd), 32'(CMD_FLUSH));
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_gnt_0", 32'(gnt_0), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_bus_cmd", 32'(bus_cmd), 32'd0);
        applyStimulus(0, 1'b1, CMD_BUSRD, 11'h011, 16'h00AA);
        applyStimulus(1, 1'b1, CMD_BUSRDX, 11'h022, 16'h00BB);
        tick(2);
        pushExpected(0, 2, CMD_BUSRD, 11'h011, 16'h00AA, 1'b0);
        pushExpected(1, 2, CMD_BUSRDX, 11'h022, 16'h00BB, 1'b0);
        rst = 1'b1;
        tick(2);
        done_0 = 1; req_0 = 0;
        tick(1);
        done_0 = 0;
        tick(2);
        done_1 = 1; req_1 = 0;
        tick(1);
        done_1 = 0;
        tick(2);

        for (int i = 0; i < 50 && expQ.size() > 0; i++) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
